// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- hazard/stall/flush controller for a 5-stage in-order pipeline.
//
// Decides every cycle which pipeline registers advance (xx_EN), which take a
// bubble (xx_FLUSH, only meaningful together with the matching EN=1) and
// whether the PC loads. Everything except `halt` and the performance counters
// is combinational from the inputs and the two state bits (RUN/HALT, drop_fetch).
//
// Ports
//   CLK, nRST           clock, asynchronous active-low reset
//   ihit                instruction fetch completes this cycle
//   dhit                MEM-stage data access completes this cycle
//   ID_rs, ID_rt        source registers of the instruction in ID
//   EX_dREN, EX_wsel    EX instruction is a load / its destination register
//   MEM_dREN, MEM_dWEN  MEM-stage data read / write request
//   branch_taken        branch resolved taken in MEM
//   jump_ID             J/JAL/JR decoded in ID
//   MEM_halt            halt instruction in MEM
//   pc_en               PC load enable
//   IF/ID/EX/MEM_EN     IF/ID, ID/EX, EX/MEM, MEM/WB register enables
//   IF/ID/EX/MEM_FLUSH  bubble insert into the same four registers
//   halt                sticky processor halt (registered)
//   stall_cnt,flush_cnt performance counters, present only with PIPE_PERF_CNT_EN
//
// Build option
//   PIPE_PERF_CNT_EN    when defined, adds saturating stall/flush counters.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EX_dREN,
  input  logic [4:0]  EX_wsel,
  input  logic        MEM_dREN,
  input  logic        MEM_dWEN,
  input  logic        branch_taken,
  input  logic        jump_ID,
  input  logic        MEM_halt,
  output logic        pc_en,
  output logic        IF_EN,
  output logic        ID_EN,
  output logic        EX_EN,
  output logic        MEM_EN,
  output logic        IF_FLUSH,
  output logic        ID_FLUSH,
  output logic        EX_FLUSH,
  output logic        MEM_FLUSH,
  output logic        halt
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  // Stage control bundle; en/flush bit 3 = IF/ID ... bit 0 = MEM/WB.
  typedef struct packed {
    logic       pc_en;
    logic [3:0] en;
    logic [3:0] flush;
  } ctl_t;

  state_t state, state_nxt;
  logic   drop_fetch, drop_nxt;
  logic   dstall, load_use, redirect;
  ctl_t   ctl;

  assign dstall   = (MEM_dREN | MEM_dWEN) & ~dhit;
  assign load_use = EX_dREN && (EX_wsel != 5'd0) &&
                    ((EX_wsel == ID_rs) || (EX_wsel == ID_rt));

  // State: drop_fetch remembers that a wrong-path fetch is still in flight
  // after a redirect, so its eventual ihit must be squashed rather than used.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= RUN;
      drop_fetch <= 1'b0;
    end else begin
      state      <= state_nxt;
      drop_fetch <= drop_nxt;
    end
  end

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    drop_nxt  = drop_fetch;
    redirect  = 1'b0;
    case (state)
      RUN: begin
        // A pending data miss freezes the whole pipe; nothing else matters.
        if (!dstall) begin
          ctl.en    = 4'b1111;
          ctl.pc_en = 1'b1;
          if (branch_taken) begin
            // Squash the three younger stages and load the branch target.
            ctl.flush = 4'b1110;
            drop_nxt  = ~ihit;
            redirect  = 1'b1;
          end else if (load_use) begin
            // Hold PC and IF/ID, feed a bubble into EX.
            ctl.pc_en    = 1'b0;
            ctl.en[3]    = 1'b0;
            ctl.flush[2] = 1'b1;
          end else if (drop_fetch && ihit) begin
            // Stale fetch finally returned: discard it, PC already redirected.
            ctl.flush[3] = 1'b1;
            ctl.pc_en    = 1'b0;
            drop_nxt     = 1'b0;
          end else if (jump_ID) begin
            ctl.flush[3] = 1'b1;
            drop_nxt     = ~ihit;
            redirect     = 1'b1;
          end else if (!ihit) begin
            ctl.flush[3] = 1'b1;
            ctl.pc_en    = 1'b0;
          end
          // MEM/WB is enabled this cycle, so the halt itself retires.
          if (MEM_halt) state_nxt = HALT;
        end
      end
      HALT: begin
        ctl.flush[0] = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
  end

  assign pc_en     = ctl.pc_en;
  assign IF_EN     = ctl.en[3];
  assign ID_EN     = ctl.en[2];
  assign EX_EN     = ctl.en[1];
  assign MEM_EN    = ctl.en[0];
  assign IF_FLUSH  = ctl.flush[3];
  assign ID_FLUSH  = ctl.flush[2];
  assign EX_FLUSH  = ctl.flush[1];
  assign MEM_FLUSH = ctl.flush[0];
  assign halt      = (state == HALT);

`ifdef PIPE_PERF_CNT_EN
  logic stall_inc;
  assign stall_inc = (state == RUN) && !ctl.pc_en;

  // Both counters saturate instead of wrapping.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != 32'hFFFF_FFFF)) stall_cnt <= stall_cnt + 32'd1;
      if (redirect  && (flush_cnt != 32'hFFFF_FFFF)) flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule
